// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame sequencer: state encoding,
// default geometry, derived widths and the window-generator latency.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int ROW_SIZE_DEF = 8;
  localparam int MAX_ROWS_DEF = 1024;
  localparam int HB           = $clog2(MAX_ROWS_DEF + 1);
  localparam int CB           = $clog2(ROW_SIZE_DEF);
  localparam int WIN_LAT      = 1;

  // A frame must be tall enough to hold one full window and no taller than the limit.
  function automatic logic height_ok(input int h, input int rows, input int max_rows);
    return (h >= rows) && (h <= max_rows);
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position tracker: column/row counter with row wrap, plus flags for the
// last pixel of the frame and for positions that complete an in-frame window.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int C_ROW_SIZE = ROW_SIZE_DEF,
  parameter int p_rows     = 3,
  parameter int p_cols     = 3,
  parameter int HW         = HB,
  parameter int CW         = CB
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [HW-1:0] height,
  output logic [CW-1:0] col,
  output logic [HW-1:0] row,
  output logic          last_pix,
  output logic          keep_ok
);

  localparam logic [CW-1:0] COL_LAST = CW'(C_ROW_SIZE - 1);

  logic [CW-1:0] col_r;
  logic [HW-1:0] row_r;

  // Position register: clear on frame start, advance on every accepted pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (clr) begin
      col_r <= '0;
      row_r <= '0;
    end else if (adv) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        row_r <= row_r + HW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  assign col      = col_r;
  assign row      = row_r;
  assign last_pix = (row_r == (height - HW'(1))) && (col_r == COL_LAST);
  assign keep_ok  = (row_r >= HW'(p_rows - 1)) && (col_r >= CW'(p_cols - 1));

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller ahead of the sliding-window generator: gates pixels, makes SOF,
// tags windows that lie fully inside the frame and counts them.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int C_ROW_SIZE = ROW_SIZE_DEF,
  parameter int p_dataBits = 8,
  parameter int p_rows     = 3,
  parameter int p_cols     = 3,
  parameter int p_maxRows  = MAX_ROWS_DEF,
  localparam int HW        = $clog2(p_maxRows + 1),
  localparam int CW        = $clog2(C_ROW_SIZE),
  localparam int WW        = HW + CW
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [HW-1:0]         cfg_height,
  input  logic [p_dataBits-1:0] pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [p_dataBits-1:0] conv_data,
  output logic                  conv_valid,
  output logic                  conv_sof,
  input  logic                  conv_busy,
  output logic                  win_keep,
  output logic [CW-1:0]         win_x,
  output logic [HW-1:0]         win_y,
  output logic [WW-1:0]         win_count,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
);

  state_t        state_r, state_nx_s;
  logic [HW-1:0] height_r;
  logic [CW-1:0] col_s;
  logic [HW-1:0] row_s;
  logic          last_pix_s, keep_ok_s;
  logic          acc_s, ready_s, start_ok_s, cfg_bad_s, done_nx_s;
  logic          win_keep_r, frame_done_r, cfg_err_r;
  logic [CW-1:0] win_x_r;
  logic [HW-1:0] win_y_r;
  logic [WW-1:0] win_count_r;

  conv_pos_counter #(
    .C_ROW_SIZE (C_ROW_SIZE),
    .p_rows     (p_rows),
    .p_cols     (p_cols),
    .HW         (HW),
    .CW         (CW)
  ) u_pos (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr      (start_ok_s),
    .adv      (acc_s),
    .height   (height_r),
    .col      (col_s),
    .row      (row_s),
    .last_pix (last_pix_s),
    .keep_ok  (keep_ok_s)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and the combinational pixel path; abort wins over an accept.
  always_comb begin
    state_nx_s = state_r;
    ready_s    = 1'b0;
    acc_s      = 1'b0;
    start_ok_s = 1'b0;
    cfg_bad_s  = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (height_ok(int'(cfg_height), p_rows, p_maxRows)) begin
            start_ok_s = 1'b1;
            state_nx_s = ST_STREAM;
          end else begin
            cfg_bad_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        ready_s = !conv_busy && !abort;
        acc_s   = pix_valid && ready_s;
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (acc_s && last_pix_s) begin
          state_nx_s = ST_DONE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  assign pix_ready  = ready_s;
  assign conv_valid = acc_s;
  assign conv_data  = acc_s ? pix_data : '0;
  assign conv_sof   = acc_s && (row_s == '0) && (col_s == '0);
  assign busy       = (state_r != ST_IDLE);

  // Window tags lag the accept by one cycle to line up with the generator output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_keep_r <= 1'b0;
      win_x_r    <= '0;
      win_y_r    <= '0;
    end else begin
      win_keep_r <= acc_s && keep_ok_s;
      if (acc_s) begin
        win_x_r <= col_s - CW'(p_cols - 1);
        win_y_r <= row_s - HW'(p_rows - 1);
      end
    end
  end

  // Frame configuration, status pulses and kept-window count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      height_r     <= '0;
      frame_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      win_count_r  <= '0;
    end else begin
      frame_done_r <= done_nx_s;
      cfg_err_r    <= cfg_bad_s;
      if (start_ok_s) begin
        height_r <= cfg_height;
      end
      if (start_ok_s) begin
        win_count_r <= '0;
      end else if (win_keep_r) begin
        win_count_r <= win_count_r + WW'(1);
      end
    end
  end

  assign win_keep   = win_keep_r;
  assign win_x      = win_x_r;
  assign win_y      = win_y_r;
  assign win_count  = win_count_r;
  assign frame_done = frame_done_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer: a pixel-count frame model checked
// every cycle, plus directed frames with hand-computed expectations.
module tb_conv_frame_sequencer;
  import conv_pkg::*;

  localparam int ROW = 8;
  localparam int NX  = ROW - 3 + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, pix_valid = 1'b0, conv_busy = 1'b0;
  logic [HB-1:0] cfg_height = '0;
  logic [7:0]    pix_data = 8'd0;
  logic          pix_ready, conv_valid, conv_sof, win_keep, busy, frame_done, cfg_err;
  logic [7:0]    conv_data;
  logic [CB-1:0] win_x;
  logic [HB-1:0] win_y;
  logic [HB+CB-1:0] win_count;

  conv_frame_sequencer #(
    .C_ROW_SIZE(ROW), .p_dataBits(8), .p_rows(3), .p_cols(3), .p_maxRows(1024)
  ) dut (
    .i_clk(clk), .i_rst(rst), .start(start), .abort(abort), .cfg_height(cfg_height),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .conv_data(conv_data), .conv_valid(conv_valid), .conv_sof(conv_sof),
    .conv_busy(conv_busy), .win_keep(win_keep), .win_x(win_x), .win_y(win_y),
    .win_count(win_count), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a run of accepted pixels numbered 0..8*h-1.
  bit m_active, m_done, m_err, m_keep;
  int m_n, m_h, m_count, m_wx, m_wy;

  always @(posedge clk or posedge rst) begin
    bit legal, take, acc, keep_n, done_n;
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_keep = 0;
      m_n = 0; m_h = 0; m_count = 0;
    end else begin
      legal  = (cfg_height >= 3) && (cfg_height <= 1024);
      take   = !m_active && !m_done && start && legal;
      acc    = m_active && !abort && !conv_busy && pix_valid;
      keep_n = acc && (m_n / ROW >= 2) && (m_n % ROW >= 2);
      done_n = acc && (m_n == ROW * m_h - 1);
      if (keep_n) begin
        m_wx = m_n % ROW - 2;
        m_wy = m_n / ROW - 2;
      end
      m_count  = take ? 0 : m_count + (m_keep ? 1 : 0);
      m_err    = !m_active && !m_done && start && !legal;
      m_keep   = keep_n;
      m_active = m_active ? (!abort && !done_n) : take;
      m_done   = done_n;
      if (take) begin
        m_h = int'(cfg_height);
        m_n = 0;
      end else if (acc) begin
        m_n++;
      end
    end
  end

  // Per-cycle comparison against the model, plus tallies for the directed checks.
  int cyc = 0, n_acc = 0, n_sof = 0, n_done = 0, n_rdy_busy = 0;
  int last_acc_cyc = 0, done_cyc = 0, sof_first = 0;
  int kx[$], ky[$];

  always @(negedge clk) begin
    bit er, ea;
    er = m_active && !conv_busy && !abort;
    ea = er && pix_valid;
    chk("busy", busy, m_active || m_done);
    chk("pix_ready", pix_ready, er);
    chk("conv_valid", conv_valid, ea);
    chk("conv_data", conv_data, ea ? pix_data : 8'd0);
    chk("conv_sof", conv_sof, ea && (m_n == 0));
    chk("win_keep", win_keep, m_keep);
    if (m_keep) begin
      chk("win_x", win_x, m_wx);
      chk("win_y", win_y, m_wy);
    end
    chk("frame_done", frame_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("win_count", win_count, m_count);

    cyc++;
    if (conv_valid) begin
      if (n_acc == 0) sof_first = conv_sof;
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (conv_sof) n_sof++;
    if (pix_ready && conv_busy) n_rdy_busy++;
    if (win_keep) begin
      kx.push_back(int'(win_x));
      ky.push_back(int'(win_y));
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  bit toggle = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_data = pix_data + 8'd7;
      if (toggle) conv_busy = ~conv_busy;
    end
  endtask

  task automatic clear_tally();
    n_acc = 0; n_sof = 0; n_done = 0; n_rdy_busy = 0; sof_first = 0;
    kx.delete(); ky.delete();
  endtask

  task automatic start_frame(input int h);
    start = 1'b1;
    cfg_height = HB'(h);
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      step(1);
      k++;
    end
    chk({tag, "_done_seen"}, n_done, 1);
  endtask

  task automatic check_keeps(input string tag, input int h);
    int exp_n = (h - 2) * NX;
    chk({tag, "_keep_n"}, kx.size(), exp_n);
    for (int i = 0; i < kx.size() && i < exp_n; i++) begin
      chk({tag, "_keep_x"}, kx[i], i % NX);
      chk({tag, "_keep_y"}, ky[i], i / NX);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    #2 rst = 1'b0;
    step(1);
    chk("rst_busy", busy, 0);
    chk("rst_win_count", win_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_keep", win_keep, 0);
    chk("rst_cfg_err", cfg_err, 0);
    pix_valid = 1'b1;

    // Full 8x4 frame, no stalls.
    clear_tally();
    start_frame(4);
    wait_done("f1", 100);
    chk("f1_accepts", n_acc, 32);
    chk("f1_sof", n_sof, 1);
    chk("f1_sof_first", sof_first, 1);
    chk("f1_done_lat", done_cyc - last_acc_cyc, 1);
    check_keeps("f1", 4);
    chk("f1_win_count", win_count, 12);

    // Same frame with conv_busy toggling every cycle.
    clear_tally();
    toggle = 1;
    start_frame(4);
    wait_done("f2", 200);
    toggle = 0;
    conv_busy = 1'b0;
    chk("f2_accepts", n_acc, 32);
    chk("f2_ready_busy", n_rdy_busy, 0);
    chk("f2_done_lat", done_cyc - last_acc_cyc, 1);
    check_keeps("f2", 4);
    chk("f2_win_count", win_count, 12);

    // Illegal heights.
    step(1);
    start_frame(2);
    chk("err_h2", cfg_err, 1);
    chk("err_h2_busy", busy, 0);
    step(1);
    start_frame(1025);
    chk("err_h1025", cfg_err, 1);
    chk("err_h1025_busy", busy, 0);
    step(1);
    chk("err_clear", cfg_err, 0);

    // Abort after 10 accepts, then a 3-row frame.
    clear_tally();
    start_frame(4);
    begin
      int k = 0;
      while (n_acc < 10 && k < 50) begin
        step(1);
        k++;
      end
    end
    abort = 1'b1;
    #1 chk("abort_ready", pix_ready, 0);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", busy, 0);
    step(5);
    chk("abort_accepts", n_acc, 10);
    chk("abort_no_done", n_done, 0);
    chk("abort_count", win_count, 0);
    clear_tally();
    start_frame(3);
    wait_done("f3", 100);
    chk("f3_sof", n_sof, 1);
    chk("f3_sof_first", sof_first, 1);
    check_keeps("f3", 3);
    chk("f3_win_count", win_count, 6);

    // Asynchronous reset in the middle of row 2.
    clear_tally();
    start_frame(4);
    step(20);
    chk("pre_rst_keep", win_keep, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", pix_ready, 0);
    chk("arst_valid", conv_valid, 0);
    chk("arst_keep", win_keep, 0);
    chk("arst_count", win_count, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    clear_tally();
    start_frame(3);
    wait_done("f4", 100);
    chk("f4_sof_first", sof_first, 1);
    check_keeps("f4", 3);

    // Back-to-back frames: start in the cycle IDLE is re-entered.
    clear_tally();
    start_frame(3);
    wait_done("f5", 100);
    chk("f5_win_count", win_count, 6);
    clear_tally();
    start_frame(3);
    chk("f6_count_restart", win_count, 0);
    wait_done("f6", 100);
    chk("f6_sof", n_sof, 1);
    chk("f6_sof_first", sof_first, 1);
    check_keeps("f6", 3);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller in front of the sliding-window generator, which takes a pixel stream with SOF and busy and emits p_rows x p_cols windows one cycle after each accepted pixel.
- Accepts a start/height command, then gates the pixel stream into the window generator and generates SOF on the first pixel.
- Tracks row/column position and flags which emitted windows lie fully inside the frame, with their top-left coordinates.
- Signals frame completion, counts kept windows and supports abort.

Parameters:
C_ROW_SIZE, 8, frame width in pixels (equals the window generator row length)
p_dataBits, 8, pixel width
p_rows, 3, window height
p_cols, 3, window width
p_maxRows, 1024, largest legal frame height

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
start  in  1  begin frame; sampled only in IDLE
abort  in  1  cancel current frame
cfg_height  in  HB=$clog2(p_maxRows+1)  frame height in rows, sampled with start
pix_data  in  p_dataBits  upstream pixel
pix_valid  in  1  upstream pixel valid
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
conv_data  out  p_dataBits  pixel to window generator
conv_valid  out  1  valid to window generator
conv_sof  out  1  SOF to window generator
conv_busy  in  1  busy from window generator
win_keep  out  1  window emitted this cycle is fully inside the frame
win_x  out  CB=$clog2(C_ROW_SIZE)  top-left column of the kept window
win_y  out  HB  top-left row of the kept window
win_count  out  HB+CB  kept windows in the current or last frame
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse
cfg_err  out  1  one-cycle pulse on illegal start

Behaviour:
Reset:
- Async, i_rst high: state IDLE; col, row, height, win_count cleared.
- Registered outputs (win_keep, win_x, win_y, frame_done, cfg_err) reset to 0.
- Applies at any time, mid-frame included; no frame_done follows.

States:
- IDLE: pix_ready=0.
  - start && p_rows<=cfg_height<=p_maxRows: latch height, clear col/row/win_count, go STREAM.
  - start with an illegal height: cfg_err=1 next cycle, stay IDLE.
- STREAM:
  - pix_ready = !conv_busy && !abort.
  - acc = pix_valid && pix_ready.
  - Combinational: conv_valid=acc; conv_data=acc ? pix_data : 0; conv_sof = acc && row==0 && col==0.
  - On acc: col increments; at C_ROW_SIZE-1 it wraps to 0 and row increments.
  - acc at (height-1, C_ROW_SIZE-1): go DONE.
  - abort (overrides acc): go IDLE; no frame_done; win_count holds its partial value.
- DONE: single cycle. frame_done=1, busy=1, pix_ready=0. Then IDLE. start is ignored in this state.

Window tagging (registered, aligned with the generator's one-cycle latency):
- win_keep <= acc && row>=p_rows-1 && col>=p_cols-1.
- win_x <= col-(p_cols-1); win_y <= row-(p_rows-1), both using the pre-increment col/row.
- If !acc, win_keep <= 0 and win_x/win_y hold.
- win_count increments when the registered win_keep is set.

Timing:
- The final window's win_keep coincides with the frame_done cycle.
- The final win_count value is visible the cycle after frame_done.

Stall:
- conv_busy high: no accept, counters hold, win_keep 0 next cycle.

Frame size:
- Total windows per frame = (height-p_rows+1)*(C_ROW_SIZE-p_cols+1).

Decomposition:
- Shared package conv_pkg holds:
  - state encoding (IDLE/STREAM/DONE)
  - localparams HB, CB
  - window-generator latency constant (1)
- One natural sub-module, conv_pos_counter: col/row counter with wrap, last-pixel and keep-qualify flags.

Test Plan:
- Defaults, height=4, pix_valid always high, conv_busy=0:
  - 32 accepts, conv_sof only on the first.
  - 12 win_keep pulses, with (win_x,win_y) covering (0..5, 0..1) in raster order.
  - frame_done one cycle after the 32nd accept; win_count=12.
- Same frame with conv_busy toggled every other cycle:
  - pix_ready=0 whenever busy; no accepts during busy cycles.
  - Identical keep sequence and win_count=12.
- start with cfg_height=2, then cfg_height=1025:
  - cfg_err pulse each time; state stays IDLE; busy=0.
- Abort after 10 accepts:
  - Abort cycle has pix_ready=0; return to IDLE; no frame_done.
  - New start, height=3: conv_sof on its first pixel; 6 keeps.
- i_rst pulsed asynchronously mid-STREAM:
  - All outputs 0 immediately; busy=0.
  - Next frame runs from (0,0).
- Back-to-back frames, start asserted the cycle IDLE is re-entered:
  - Second frame's first accept carries conv_sof.
  - win_count restarts at 0.
